arm_microseq: RTL
=================

# arm_microseq

Microprogrammed control unit for the multicycle ARM core. It replaces the hardwired multicycle controller and drives the same datapath control strobes from a micro-PC and an internal micro-store. Compared with the hardwired controller it adds three things: a variable-latency memory handshake (`MemReady`), an internal condition-flag register with full 16-code condition evaluation, and an optional stall watchdog that parks the core in a fault state.

## Interface
- `UPC_W`, 4: micro-PC width; must be ≥4. Micro-states 0–10 are used; unused codes decode as HALT.
- `TIMEOUT`, 255: consecutive stalled cycles allowed before the fault; must be ≥1.
- `TMO_W`, `$clog2(TIMEOUT+1)`: watchdog counter width (derived).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `Instr`  in  20  instruction bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
- `ALUFlags`  in  4  {N,Z,C,V} from the datapath ALU.
- `MemReady`  in  1  memory has completed the current access this cycle.
- `PCWrite`, `MemWrite`, `RegWrite`, `IRWrite`, `AdrSrc`, `ALUSrcA`  out  1  datapath strobes and selects.
- `RegSrc`, `ALUSrcB`, `ResultSrc`, `ImmSrc`, `ALUControl`  out  2  datapath selects.
- `Fault`  out  1  watchdog fired; the core is halted.
- `UPC`  out  `UPC_W`  current micro-state (debug).

## Operation
- **Micro-states:** 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXECR, 7 EXECI, 8 ALUWB, 9 BRANCH, 10 HALT.
- **Transitions:**
  - FETCH→DECODE when `MemReady`=1; otherwise hold.
  - DECODE dispatches on Op/Funct[5]:
    - Op=00, Funct[5]=0 → EXECR.
    - Op=00, Funct[5]=1 → EXECI.
    - Op=01 → MEMADR.
    - Op=10 → BRANCH.
    - Op=11 → FETCH (no-op).
  - MEMADR→MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD→MEMWB when `MemReady`=1.
  - MEMWR→FETCH when `MemReady`=1.
  - EXECR/EXECI→ALUWB.
  - MEMWB/ALUWB/BRANCH→FETCH.
  - HALT→HALT.
- **Micro-word outputs** (any field not listed is 0):
  - FETCH: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=PCWrite=`MemReady`.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite.
  - MEMWR: AdrSrc=1, MemWrite (held for the whole wait).
  - EXECR: ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegWrite.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- **Instruction decode** (combinational):
  - ImmSrc=Op.
  - RegSrc[0]=(Op==10); RegSrc[1]=(Op==01).
  - ALUControl when ALUOp=1, keyed on Funct[4:1]:
    - 0100 → 00 (ADD).
    - 0010 → 01 (SUB).
    - 0000 → 10 (AND).
    - 1100 → 11 (ORR).
    - any other code → 00.
  - ALUControl=00 when ALUOp=0.
- **CondEx:** standard ARM evaluation of Cond against the internal flags register {N,Z,C,V}. Codes 0000 EQ … 1101 LE, 1110 AL; 1111 evaluates false.
- **Condition gating:**
  - RegWrite, MemWrite and branch PCWrite are ANDed with CondEx.
  - FETCH's PCWrite/IRWrite are not gated.
  - PCWrite is also asserted when gated RegWrite=1 and Rd=1111.
- **Flag register:**
  - Written on the clock edge that ends EXECR/EXECI, when CondEx=1 and Funct[0]=1.
  - N,Z are always loaded from `ALUFlags`.
  - C,V are loaded only if ALUControl is 00 or 01.
- **Reset:** while `reset`=0, every output is 0, UPC is 0 and the flags register is 0. At the first edge with `reset`=1 the core is in FETCH, with its outputs driven combinationally in that cycle.

## Timing
- One micro-state per cycle when `MemReady`=1 throughout. Cycle counts per instruction:
  - Data-processing: 4 (FETCH, DECODE, EXEC, ALUWB).
  - LDR: 5.
  - STR: 4.
  - Branch: 3.
- Each stalled cycle in FETCH, MEMRD or MEMWR adds one cycle. The state holds, and all strobes except MemWrite are held at 0 during the stall.
- All outputs are Moore-style decodes of UPC and the registered flags. The exceptions are `MemReady`-qualified IRWrite/PCWrite and the `Instr`-derived selects; these are combinational and have no added latency.
- `reset` low mid-instruction aborts the instruction on the next edge; no partial write is asserted during the reset cycle.

## Configuration
- **Macro:** `ARM_MICROSEQ_TIMEOUT_EN`.
- **Defined:**
  - The watchdog counter increments on each cycle spent in FETCH/MEMRD/MEMWR with `MemReady`=0.
  - It clears on `MemReady`=1 or on any state change.
  - When the count reaches `TIMEOUT` with `MemReady` still 0, the next state is HALT. HALT is 1 cycle after the `TIMEOUT`-th stalled cycle.
  - In HALT: `Fault`=1, all strobes 0. Only `reset` exits.
- **Undefined:** no counter; stalls are unbounded; `Fault` is tied 0; HALT is unreachable.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `MemReady`=1 → all outputs 0, UPC=0. Release → FETCH with PCWrite=IRWrite=1, UPC=1 on the next edge.
- **ADD R1,R2,R3:** `Instr`=0xE0821, `MemReady`=1 → UPC sequence 0,1,6,8,0; ALUControl=00 in EXECR; RegWrite=1 only in ALUWB; PCWrite=0 in ALUWB.
- **LDR with wait:** `Instr`=0xE5921, `MemReady`=0 for 3 cycles in MEMRD → UPC holds at 3 for 4 cycles with AdrSrc=1, then MEMWB with RegWrite=1; 8 cycles total.
- **SUBS then BEQ/BNE:** SUBS (`Instr`=0xE0521) with `ALUFlags`=0100 during EXECR → flags Z=1. Then BEQ (`Instr`=0x0A000) → PCWrite=1 in BRANCH; BNE (`Instr`=0x1A000) → PCWrite=0.
- **Write to PC:** ADD R15 (`Instr`=0xE082F) → RegWrite=1 and PCWrite=1 in ALUWB. With Cond=0000 and Z=0, both are 0.
- **Watchdog** (macro defined, `TIMEOUT`=255): `MemReady`=0 held in FETCH → `Fault`=0 through stalled cycle 255, then UPC=10 and `Fault`=1 with all strobes 0 until `reset`. With the macro undefined, UPC stays at 0 indefinitely.

Source files
------------

// File: rtl/arm_microseq.sv
// Microprogrammed multicycle ARM controller: micro-PC sequencer, micro-word decode,
// condition flags and CondEx. Optional stall watchdog under ARM_MICROSEQ_TIMEOUT_EN.
module arm_microseq #(
  parameter int UPC_W   = 4,
  parameter int TIMEOUT = 255,
  parameter int TMO_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [19:0]      Instr,
  input  logic [3:0]       ALUFlags,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic             ALUSrcA,
  output logic [1:0]       RegSrc,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       ALUControl,
  output logic             Fault,
  output logic [UPC_W-1:0] UPC
);

  // Handshake: MemReady=1 in FETCH/MEMRD/MEMWR means the access completes on this
  // cycle's rising edge; while it is 0 the micro-state holds and only MemWrite stays up.

  typedef enum logic [UPC_W-1:0] {
    S_FETCH  = UPC_W'(0),
    S_DECODE = UPC_W'(1),
    S_MEMADR = UPC_W'(2),
    S_MEMRD  = UPC_W'(3),
    S_MEMWB  = UPC_W'(4),
    S_MEMWR  = UPC_W'(5),
    S_EXECR  = UPC_W'(6),
    S_EXECI  = UPC_W'(7),
    S_ALUWB  = UPC_W'(8),
    S_BRANCH = UPC_W'(9),
    S_HALT   = UPC_W'(10)
  } state_t;

  state_t state, state_nxt;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_instr;

  assign cond         = Instr[19:16];
  assign op           = Instr[15:14];
  assign funct        = Instr[13:8];
  assign rd           = Instr[3:0];
  assign unused_instr = ^Instr[7:4];

  // Micro-word fields
  logic       mw_asa;
  logic [1:0] mw_asb;
  logic [1:0] mw_rs;
  logic       mw_adr;
  logic       mw_regw;
  logic       mw_memw;
  logic       mw_branch;
  logic       mw_aluop;

  logic       stall_state;
  logic       wd_fire;

  // Flags register {N,Z,C,V}
  logic [3:0] flags;
  logic       cond_ex;
  logic [1:0] alu_dec;

  assign stall_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

  always_comb begin
    logic fn, fz, fc, fv;
    fn = flags[3];
    fz = flags[2];
    fc = flags[1];
    fv = flags[0];
    cond_ex = 1'b0;
    case (cond)
      4'h0: cond_ex = fz;
      4'h1: cond_ex = ~fz;
      4'h2: cond_ex = fc;
      4'h3: cond_ex = ~fc;
      4'h4: cond_ex = fn;
      4'h5: cond_ex = ~fn;
      4'h6: cond_ex = fv;
      4'h7: cond_ex = ~fv;
      4'h8: cond_ex = fc & ~fz;
      4'h9: cond_ex = ~fc | fz;
      4'hA: cond_ex = (fn == fv);
      4'hB: cond_ex = (fn != fv);
      4'hC: cond_ex = ~fz & (fn == fv);
      4'hD: cond_ex = fz | (fn != fv);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    alu_dec = 2'b00;
    case (funct[4:1])
      4'b0100: alu_dec = 2'b00;
      4'b0010: alu_dec = 2'b01;
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      default: alu_dec = 2'b00;
    endcase
  end

  // Micro-store: next micro-PC and micro-word for the current micro-state
  always_comb begin
    state_nxt = state;
    mw_asa    = 1'b0;
    mw_asb    = 2'b00;
    mw_rs     = 2'b00;
    mw_adr    = 1'b0;
    mw_regw   = 1'b0;
    mw_memw   = 1'b0;
    mw_branch = 1'b0;
    mw_aluop  = 1'b0;
    case (state)
      S_FETCH: begin
        mw_asa = 1'b1;
        mw_asb = 2'b10;
        mw_rs  = 2'b10;
        if (MemReady) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        mw_asa = 1'b1;
        mw_asb = 2'b10;
        mw_rs  = 2'b10;
        case (op)
          2'b00:   state_nxt = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_nxt = S_MEMADR;
          2'b10:   state_nxt = S_BRANCH;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        mw_asb    = 2'b01;
        state_nxt = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mw_adr = 1'b1;
        if (MemReady) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        mw_rs     = 2'b01;
        mw_regw   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        mw_adr  = 1'b1;
        mw_memw = 1'b1;
        if (MemReady) state_nxt = S_FETCH;
      end
      S_EXECR: begin
        mw_aluop  = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        mw_asb    = 2'b01;
        mw_aluop  = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        mw_regw   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        mw_asb    = 2'b01;
        mw_rs     = 2'b10;
        mw_branch = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_HALT;
    endcase
    if (wd_fire) state_nxt = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

`ifdef ARM_MICROSEQ_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_cnt;

  // The TIMEOUT-th consecutive stalled cycle redirects the next state to HALT.
  assign wd_fire = stall_state && !MemReady && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!reset)
      tmo_cnt <= '0;
    else if (stall_state && !MemReady && (state_nxt == state))
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    else
      tmo_cnt <= '0;
  end

  assign Fault = reset && (state == S_HALT);
`else
  logic [TMO_W-1:0] unused_tmo;
  logic             unused_stall;
  assign unused_tmo   = TMO_W'(TIMEOUT);
  assign unused_stall = stall_state;
  assign wd_fire      = 1'b0;
  assign Fault        = 1'b0;
`endif

  // Flags update on the edge that ends an execute micro-state
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags <= 4'b0000;
    end else if ((state == S_EXECR || state == S_EXECI) && cond_ex && funct[0]) begin
      flags[3:2] <= ALUFlags[3:2];
      if (alu_dec == 2'b00 || alu_dec == 2'b01) flags[1:0] <= ALUFlags[1:0];
    end
  end

  logic fetch_go;
  logic regw_g;

  assign fetch_go = (state == S_FETCH) && MemReady;
  assign regw_g   = mw_regw && cond_ex;

  assign PCWrite    = reset && (fetch_go || (mw_branch && cond_ex) || (regw_g && rd == 4'hF));
  assign IRWrite    = reset && fetch_go;
  assign RegWrite   = reset && regw_g;
  assign MemWrite   = reset && mw_memw && cond_ex;
  assign AdrSrc     = reset && mw_adr;
  assign ALUSrcA    = reset && mw_asa;
  assign ALUSrcB    = reset ? mw_asb : 2'b00;
  assign ResultSrc  = reset ? mw_rs : 2'b00;
  assign ImmSrc     = reset ? op : 2'b00;
  assign RegSrc     = reset ? {op == 2'b01, op == 2'b10} : 2'b00;
  assign ALUControl = (reset && mw_aluop) ? alu_dec : 2'b00;
  assign UPC        = reset ? state : '0;

endmodule
